// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback trace encoder.
// One commit becomes three bytes: header {marker, 0, rd}, data high, data low.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_TERM = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [3:0] MARKER            = 4'hA;
  localparam logic [7:0] HALT_CODE_DEFAULT = 8'hF0;
  localparam int         PKT_BYTES         = 3;
  localparam int         RD_W              = 3;
  localparam int         DATA_W            = 16;
  localparam int         ENTRY_W           = RD_W + DATA_W;

  function automatic logic [7:0] hdr_byte(input logic [RD_W-1:0] rd);
    return {MARKER, 1'b0, rd};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Commit FIFO with an extra pointer bit for full/empty and a registered head output.
// dout always shows the entry that will be at the head after this cycle's push/pop.
module trace_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, rd_next;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rd_next = do_pop ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_next;
      // Forward the incoming entry when it becomes the new head.
      if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) dout <= din;
      else                                                 dout <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/wb_trace_encoder.sv
// Serialises writeback commits into a 3-byte-per-commit trace stream,
// terminated by HALT_CODE once the processor halts and the queue drains.
module wb_trace_encoder
  import trace_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_valid,
  input  logic [2:0]   wb_rd,
  input  logic [15:0]  wb_data,
  input  logic         halt,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         overflow,
  output logic         done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t              state, state_nx;
  logic                halt_seen;
  logic                hs, capture, pop, push_ok, more;
  logic                full, empty;
  logic [AW:0]         count;
  logic [ENTRY_W-1:0]  head;

  assign hs      = tx_valid && tx_ready;
  // The first halt cycle still captures; halt_seen blocks later commits.
  assign capture = wb_valid && !halt_seen;
  assign pop     = (state == ST_B2) && hs;
  assign push_ok = capture && (!full || pop);
  assign more    = (count > CNT_ONE) || push_ok;

  trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .din   ({wb_rd, wb_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nx = state;
    case (state)
      // Checking push_ok gives byte0 the cycle after a commit into an idle encoder.
      ST_IDLE: if (!empty || push_ok) state_nx = ST_B0;
               else if (halt_seen)     state_nx = ST_TERM;
      ST_B0:   if (tx_ready) state_nx = ST_B1;
      ST_B1:   if (tx_ready) state_nx = ST_B2;
      ST_B2:   if (tx_ready) state_nx = more ? ST_B0 : ST_IDLE;
      ST_TERM: if (tx_ready) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      halt_seen <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (halt) halt_seen <= 1'b1;
      if (capture && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      ST_B0:   begin tx_valid = 1'b1; tx_data = hdr_byte(head[ENTRY_W-1:DATA_W]); end
      ST_B1:   begin tx_valid = 1'b1; tx_data = head[15:8];                        end
      ST_B2:   begin tx_valid = 1'b1; tx_data = head[7:0];                         end
      ST_TERM: begin tx_valid = 1'b1; tx_data = HALT_CODE;                         end
      default: ;
    endcase
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_wb_trace_encoder.sv
// Randomised and directed bench for wb_trace_encoder against a queue-level model.
module tb_wb_trace_encoder;

  localparam int DEPTH = 8;
  localparam logic [7:0] HCODE = 8'hF0;

  logic        clk = 1'b0;
  logic        reset, wb_valid, halt, tx_ready;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [7:0]  tx_data;
  logic        tx_valid, overflow, done;

  int compared = 0;
  int mismatched = 0;

  wb_trace_encoder #(.DEPTH(DEPTH), .HALT_CODE(HCODE)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .halt     (halt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Model: queue of pending commits (head is the one on the wire) and byte position.
  logic [18:0] mq[$];
  int          bidx = 0;
  bit          m_halt = 0, m_term = 0, m_done = 0, m_ovf = 0, chk_en = 0;
  logic [7:0]  cap[$];

  function automatic bit exp_valid();
    return (mq.size() > 0) || m_term;
  endfunction

  function automatic logic [7:0] exp_byte();
    logic [18:0] e;
    if (mq.size() == 0) return HCODE;
    e = mq[0];
    if (bidx == 0) return {4'hA, 1'b0, e[18:16]};
    if (bidx == 1) return e[15:8];
    return e[7:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      bidx = 0; m_halt = 0; m_term = 0; m_done = 0; m_ovf = 0;
      chk_en = 1;
    end else begin
      bit hs, was_empty, go_term;
      hs        = exp_valid() && tx_ready;
      was_empty = (mq.size() == 0);
      go_term   = was_empty && m_halt && !m_term && !m_done;
      if (hs) begin
        if (mq.size() > 0) begin
          if (bidx == 2) begin void'(mq.pop_front()); bidx = 0; end
          else bidx++;
        end else begin
          m_term = 0; m_done = 1;
        end
      end
      if (wb_valid && !m_halt) begin
        if (mq.size() < DEPTH) mq.push_back({wb_rd, wb_data});
        else m_ovf = 1;
      end
      if (go_term) m_term = 1;
      if (halt) m_halt = 1;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    if (chk_en) begin
      cmp("tx_valid", 32'(tx_valid), 32'(exp_valid()));
      if (exp_valid()) cmp("tx_data", 32'(tx_data), 32'(exp_byte()));
      cmp("overflow", 32'(overflow), 32'(m_ovf));
      cmp("done", 32'(done), 32'(m_done));
    end
  endtask

  task automatic tick();
    if (tx_valid === 1'b1 && tx_ready === 1'b1) cap.push_back(tx_data);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1; wb_valid = 0; halt = 0;
    tick();
    reset = 0;
    cap.delete();
  endtask

  task automatic commit(input logic [2:0] rd, input logic [15:0] d);
    wb_valid = 1; wb_rd = rd; wb_data = d;
    tick();
    wb_valid = 0;
  endtask

  initial begin
    reset = 1; wb_valid = 0; wb_rd = 0; wb_data = 0; halt = 0; tx_ready = 1;
    tick(); tick();
    cmp("reset_tx_valid", 32'(tx_valid), 0);
    cmp("reset_tx_data", 32'(tx_data), 0);
    reset = 0;
    tick();
    cmp("idle_overflow", 32'(overflow), 0);
    cmp("idle_done", 32'(done), 0);

    // Single commit, byte0 one cycle later
    commit(3'd3, 16'h1234);
    cmp("single_b0_valid", 32'(tx_valid), 1);
    cmp("single_b0", 32'(tx_data), 32'h A3);
    tick(); cmp("single_b1", 32'(tx_data), 32'h12);
    tick(); cmp("single_b2", 32'(tx_data), 32'h34);
    tick(); cmp("single_end_valid", 32'(tx_valid), 0);

    // Backpressure on byte1
    commit(3'd5, 16'h1234);
    tick();
    tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("bp_hold_valid", 32'(tx_valid), 1);
      cmp("bp_hold_data", 32'(tx_data), 32'h12);
    end
    tx_ready = 1;
    tick(); cmp("bp_resume_b2", 32'(tx_data), 32'h34);
    tick();

    // Overflow: 9 commits into 8 entries while stalled
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 9; i++) commit(3'(i), 16'(i * 16'h1111));
    cmp("ovf_set", 32'(overflow), 1);
    tx_ready = 1;
    cap.delete();
    for (int i = 0; i < 30; i++) tick();
    cmp("ovf_bytes", 32'(cap.size()), 24);
    if (cap.size() == 24) begin
      cmp("ovf_first_hdr", 32'(cap[0]), 32'hA0);
      cmp("ovf_last_hdr", 32'(cap[21]), 32'hA7);
      cmp("ovf_last_lo", 32'(cap[23]), 32'h77);
    end
    cmp("ovf_sticky", 32'(overflow), 1);

    // Reset while byte1 is on the wire
    commit(3'd2, 16'hABCD);
    tick();
    reset = 1;
    tick();
    cmp("rst_mid_valid", 32'(tx_valid), 0);
    reset = 0;
    commit(3'd6, 16'h0102);
    cmp("rst_restart_b0", 32'(tx_data), 32'hA6);
    cmp("rst_ovf_clear", 32'(overflow), 0);
    cmp("rst_done_clear", 32'(done), 0);
    for (int i = 0; i < 4; i++) tick();

    // Push on the B2 pop handshake while full
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 8; i++) commit(3'(i), 16'(i * 16'h0101));
    tx_ready = 1;
    tick(); tick();
    cmp("fullpop_in_b2", 32'(tx_data), 32'h00);
    commit(3'd1, 16'hBEEF);
    cmp("fullpop_no_ovf", 32'(overflow), 0);
    cap.delete();
    for (int i = 0; i < 30; i++) tick();
    cmp("fullpop_bytes", 32'(cap.size()), 24);
    if (cap.size() == 24) begin
      cmp("fullpop_new_hdr", 32'(cap[21]), 32'hA1);
      cmp("fullpop_new_lo", 32'(cap[23]), 32'hEF);
    end

    // Halt with a coincident commit, then ignored commits
    do_reset();
    commit(3'd1, 16'h1111);
    commit(3'd2, 16'h2222);
    halt = 1;
    commit(3'd7, 16'hFFFF);
    wb_valid = 1; wb_rd = 3'd4; wb_data = 16'h4444;
    for (int i = 0; i < 30 && done !== 1'b1; i++) tick();
    cmp("halt_done", 32'(done), 1);
    cmp("halt_bytes", 32'(cap.size()), 10);
    if (cap.size() == 10) begin
      cmp("halt_b_hdr7", 32'(cap[6]), 32'hA7);
      cmp("halt_b_ff", 32'(cap[7]), 32'hFF);
      cmp("halt_term", 32'(cap[9]), 32'hF0);
    end
    for (int i = 0; i < 5; i++) tick();
    cmp("halt_quiet", 32'(tx_valid), 0);
    wb_valid = 0; halt = 0;

    // Random phases: mostly-ready, then heavy backpressure to force drops
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        wb_valid = ($urandom_range(0, 99) < (ph == 0 ? 40 : 60));
        wb_rd    = 3'($urandom);
        wb_data  = 16'($urandom);
        tx_ready = ($urandom_range(0, 99) < (ph == 0 ? 80 : 20));
        tick();
      end
      halt = 1; wb_valid = 0; tx_ready = 1;
      for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
      cmp("rand_done", 32'(done), 1);
      halt = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_trace_encoder.md
WB_TRACE_ENCODER -- requirements
Module: wb_trace_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning commit-FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter HALT_CODE, default 8'hF0, meaning the terminator byte sent after halt.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wb_valid  input  1  writeback commit this cycle (RegWrite_final).
REQ-006 wb_rd  input  3  destination register of the commit (R0..R7).
REQ-007 wb_data  input  16  value written by the commit (write_data_WB).
REQ-008 halt  input  1  processor halt indication (level).
REQ-009 tx_data  output  8  trace byte.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready.
REQ-012 overflow  output  1  sticky: at least one commit was dropped.
REQ-013 done  output  1  terminator byte accepted; stream complete.

Function
REQ-014 Each captured commit SHALL be stored as one 19-bit FIFO entry {rd, data}.
REQ-015 Each entry SHALL be sent as 3 bytes in order: {4'hA, 1'b0, rd}, data[15:8], data[7:0].
REQ-016 Serializer FSM states SHALL be IDLE, B0, B1, B2, TERM, DONE.
REQ-017 IDLE->B0 when the FIFO is non-empty; IDLE->TERM when halt_seen and the FIFO is empty; otherwise stay in IDLE.
REQ-018 B0->B1->B2 SHALL advance only on a handshake; on the B2 handshake, pop the entry and go to B0 if another entry remains, else IDLE.
REQ-019 TERM SHALL present HALT_CODE; on the handshake go to DONE; DONE is absorbing until reset.
REQ-020 tx_valid SHALL be high exactly in B0, B1, B2 and TERM; tx_data SHALL stay stable while tx_valid && !tx_ready.
REQ-021 Latency: wb_valid at cycle N into an empty FIFO with the FSM in IDLE SHALL give tx_valid with byte0 at cycle N+1.
REQ-022 Back-to-back packets SHALL have no idle cycle between them when tx_ready stays high (3 cycles per packet).
REQ-023 Push while full SHALL drop the commit and set overflow; it SHALL NOT be dropped if the B2 pop handshake occurs in the same cycle.
REQ-024 Push and pop in the same cycle on a non-full FIFO SHALL keep occupancy unchanged.
REQ-025 The halt_seen flag SHALL set on the first cycle halt=1.
REQ-026 A wb_valid coincident with that first halt cycle SHALL still be captured; commits after halt_seen SHALL be ignored.
REQ-027 All entries queued before halt SHALL be transmitted before HALT_CODE.
REQ-028 Writes to any rd, including R0, SHALL be traced.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-030 On reset, the module SHALL set state=IDLE, clear the FIFO, and clear halt_seen, overflow and done.
REQ-031 On reset, tx_valid SHALL be 0 and tx_data SHALL be 8'h00.
REQ-032 Reset mid-packet SHALL abandon the packet; the first post-reset byte SHALL be a fresh byte0.

Structure
REQ-033 A shared package trace_pkg SHALL hold the FSM state enum, the 4'hA marker, the HALT_CODE default and the packet byte count 3.
REQ-034 The FIFO SHALL be a sub-module trace_fifo (parameterised WIDTH and DEPTH; push, pop, full, empty, registered dout).

Verification
REQ-035 Single commit: rd=3, data=16'h1234, tx_ready=1 -> bytes A3, 12, 34 on cycles N+1..N+3.
REQ-036 Backpressure: tx_ready=0 for 5 cycles during byte1 -> tx_data holds 8'h12 with tx_valid=1 throughout; the stream resumes unchanged.
REQ-037 Overflow: tx_ready=0 with 9 commits at DEPTH=8 -> overflow=1; release -> exactly 8 packets, in order.
REQ-038 Full plus pop: a push on the same cycle as the B2 handshake while full -> no drop, and overflow stays 0.
REQ-039 Halt: 2 queued commits, then halt with a coincident commit rd=7, data=FFFF -> 3 packets then F0, done=1; later commits produce no bytes.
REQ-040 Reset during byte1 -> tx_valid=0 for the next cycle; a new commit then restarts at byte0 with overflow=0 and done=0.
